// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one adder among NREQ requesters.
// Optional WAIT timeout abort is enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter #(
   parameter int inSize  = 4,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*inSize-1:0]   opA,
   input  logic [NREQ*inSize-1:0]   opB,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          res_valid,
   output logic [inSize:0]          res_sum,
   output logic                     res_err,
   output logic                     busy,
   output logic                     add_en,
   output logic [inSize-1:0]        add_A,
   output logic [inSize-1:0]        add_B,
   input  logic [inSize:0]          add_sum,
   input  logic                     add_valid
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_err
      $error("adder_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic [PW-1:0]         ptr, ptr_nx;
   logic [PW-1:0]         win, win_nx;
   logic [PW-1:0]         pick;
   logic [NREQ-1:0]       gnt_nx, rv_nx;
   logic [inSize-1:0]     a_nx, b_nx;
   logic [inSize:0]       sum_nx;
   logic                  en_nx, busy_nx;

`ifdef ADDER_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  err_nx;
   logic                  err_q;
`endif

   // First set request at or above p, wrapping around to the low indices.
   function automatic logic [PW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                 input logic [PW-1:0]   p);
      logic [PW-1:0] w;
      logic          found;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && r[i] && (PW'(i) >= p)) begin
            w     = PW'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && r[i] && (PW'(i) < p)) begin
            w     = PW'(i);
            found = 1'b1;
         end
      end
      return w;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
      logic [NREQ-1:0] v;
      v = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == idx) v[i] = 1'b1;
      end
      return v;
   endfunction

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      win_nx   = win;
      a_nx     = add_A;
      b_nx     = add_B;
      sum_nx   = res_sum;
      gnt_nx   = '0;
      rv_nx    = '0;
      en_nx    = 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
      cnt_nx   = cnt;
      err_nx   = err_q;
`endif
      pick     = pick_winner(req, ptr);

      case (state)
         IDLE: begin
            if (|req) begin
               win_nx   = pick;
               gnt_nx   = onehot(pick);
               en_nx    = 1'b1;
               state_nx = ISSUE;
               for (int i = 0; i < NREQ; i++) begin
                  if (PW'(i) == pick) begin
                     a_nx = opA[i*inSize +: inSize];
                     b_nx = opB[i*inSize +: inSize];
                  end
               end
            end
         end
         ISSUE: begin
            state_nx = WAIT;
`ifdef ADDER_ARB_TIMEOUT_EN
            cnt_nx   = '0;
`endif
         end
         WAIT: begin
            // A valid result on the expiry cycle takes priority over the abort.
            if (add_valid) begin
               sum_nx   = add_sum;
               rv_nx    = onehot(win);
               state_nx = RESP;
`ifdef ADDER_ARB_TIMEOUT_EN
               err_nx   = 1'b0;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               sum_nx   = '0;
               err_nx   = 1'b1;
               rv_nx    = onehot(win);
               state_nx = RESP;
            end else begin
               cnt_nx   = cnt + CW'(1);
`endif
            end
         end
         RESP: begin
            ptr_nx   = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         win       <= '0;
         gnt       <= '0;
         res_valid <= '0;
         res_sum   <= '0;
         busy      <= 1'b0;
         add_en    <= 1'b0;
         add_A     <= '0;
         add_B     <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
         cnt       <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         win       <= win_nx;
         gnt       <= gnt_nx;
         res_valid <= rv_nx;
         res_sum   <= sum_nx;
         busy      <= busy_nx;
         add_en    <= en_nx;
         add_A     <= a_nx;
         add_B     <= b_nx;
`ifdef ADDER_ARB_TIMEOUT_EN
         cnt       <= cnt_nx;
         err_q     <= err_nx;
`endif
      end
   end

`ifdef ADDER_ARB_TIMEOUT_EN
   assign res_err = err_q;
`else
   assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with a variable-latency adder model.
module tb_adder_arbiter;

   localparam int inSize  = 4;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NREQ-1:0]         req;
   logic [NREQ*inSize-1:0]  opA, opB;
   logic [NREQ-1:0]         gnt, res_valid;
   logic [inSize:0]         res_sum;
   logic                    res_err, busy, add_en;
   logic [inSize-1:0]       add_A, add_B;
   logic [inSize:0]         add_sum;
   logic                    add_valid;

   int n_chk = 0;
   int n_err = 0;

   // Adder model: valid arrives lat cycles after en; lat = 0 means never.
   int              lat  = 1;
   logic            inj  = 1'b0;
   logic            av   = 1'b0;
   logic            pend = 1'b0;
   int              cd   = 0;
   logic [inSize:0] s_r  = '0;

   assign add_sum   = s_r;
   assign add_valid = av | inj;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      av <= 1'b0;
      if (add_en) begin
         s_r <= add_A + add_B;
         if (lat == 1) begin
            av <= 1'b1;
         end else if (lat > 1) begin
            cd   <= lat - 1;
            pend <= 1'b1;
         end
      end else if (pend) begin
         if (cd == 1) begin
            av   <= 1'b1;
            pend <= 1'b0;
         end
         cd <= cd - 1;
      end
   end

   adder_arbiter #(.inSize(inSize), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .opA(opA), .opB(opB),
      .gnt(gnt), .res_valid(res_valid), .res_sum(res_sum), .res_err(res_err),
      .busy(busy), .add_en(add_en), .add_A(add_A), .add_B(add_B),
      .add_sum(add_sum), .add_valid(add_valid)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_op(input int i, input int a, input int b);
      opA[i*inSize +: inSize] = inSize'(a);
      opB[i*inSize +: inSize] = inSize'(b);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      opA = '0;
      opB = '0;

      // Reset and idle
      tick;
      tick;
      check("rst_gnt", gnt, 0);
      check("rst_rv", res_valid, 0);
      check("rst_sum", res_sum, 0);
      check("rst_err", res_err, 0);
      check("rst_busy", busy, 0);
      check("rst_en", add_en, 0);
      check("rst_A", add_A, 0);
      check("rst_B", add_B, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("idle_busy", busy, 0);
         check("idle_gnt", gnt, 0);
      end

      // Single request, adder latency 1
      set_op(0, 1, 2);
      req = 4'b0001;
      lat = 1;
      tick;
      check("s_gnt", gnt, 4'b0001);
      check("s_en", add_en, 1);
      check("s_A", add_A, 1);
      check("s_B", add_B, 2);
      check("s_busy", busy, 1);
      req = '0;
      tick;
      check("s_gnt_off", gnt, 0);
      check("s_en_off", add_en, 0);
      check("s_rv_early", res_valid, 0);
      tick;
      check("s_rv", res_valid, 4'b0001);
      check("s_sum", res_sum, 3);
      check("s_err", res_err, 0);
      check("s_busy_resp", busy, 1);
      tick;
      check("s_rv_off", res_valid, 0);
      check("s_busy_off", busy, 0);

      // Carry case on requester 2, adder latency 3, stray valid during ISSUE
      set_op(2, 15, 15);
      req = 4'b0100;
      lat = 3;
      tick;
      check("c_gnt", gnt, 4'b0100);
      check("c_A", add_A, 15);
      req = '0;
      inj = 1'b1;
      tick;
      inj = 1'b0;
      check("c_rv2", res_valid, 0);
      tick;
      check("c_rv3", res_valid, 0);
      tick;
      check("c_rv4", res_valid, 0);
      check("c_A_hold", add_A, 15);
      tick;
      check("c_rv", res_valid, 4'b0100);
      check("c_sum", res_sum, 30);
      check("c_err", res_err, 0);
      tick;
      check("c_busy_off", busy, 0);

      // Reset while waiting on a never-valid adder
      set_op(3, 3, 4);
      req = 4'b1000;
      lat = 0;
      tick;
      check("r_gnt", gnt, 4'b1000);
      req = '0;
      tick;
      check("r_busy_wait", busy, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("r_busy", busy, 0);
      check("r_rv", res_valid, 0);
      check("r_A", add_A, 0);
      set_op(1, 2, 9);
      req = 4'b1010;
      lat = 1;
      tick;
      check("r_gnt_ptr0", gnt, 4'b0010);
      req = '0;
      tick;
      tick;
      check("r_rv_after", res_valid, 4'b0010);
      check("r_sum_after", res_sum, 11);
      tick;

      // Round robin with all four requesters held high from reset
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10 + i);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req = 4'b1111;
      lat = 1;
      for (int k = 0; k < 5; k++) begin
         tick;
         check("rr_gnt", gnt, 32'(1) << (k % 4));
         check("rr_A", add_A, (k % 4) + 1);
         tick;
         check("rr_gap", gnt, 0);
         tick;
         check("rr_rv", res_valid, 32'(1) << (k % 4));
         check("rr_sum", res_sum, 2 * (k % 4) + 11);
         tick;
         check("rr_idle_gnt", gnt, 0);
         check("rr_idle_busy", busy, 0);
      end
      req = '0;
      tick;

`ifdef ADDER_ARB_TIMEOUT_EN
      // Timeout abort; winner pointer is 1 here
      set_op(1, 5, 6);
      req = 4'b0010;
      lat = 0;
      tick;
      check("t_gnt", gnt, 4'b0010);
      req = '0;
      for (int i = 0; i < 15; i++) tick;
      check("t_rv_early", res_valid, 0);
      tick;
      check("t_rv", res_valid, 4'b0010);
      check("t_err", res_err, 1);
      check("t_sum", res_sum, 0);
      tick;

      // Valid on the expiry cycle wins
      set_op(2, 7, 8);
      req = 4'b0100;
      lat = 15;
      tick;
      check("tv_gnt", gnt, 4'b0100);
      req = '0;
      for (int i = 0; i < 15; i++) tick;
      check("tv_rv_early", res_valid, 0);
      tick;
      check("tv_rv", res_valid, 4'b0100);
      check("tv_err", res_err, 0);
      check("tv_sum", res_sum, 15);
      tick;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
